// File: rtl/id_decode_stage.sv
// LA32R instruction-decode stage: full decode of the ID instruction into the
// core's control fields, registered into a valid/ready EX output register with
// flush and a one-bubble load-use interlock.
module id_decode_stage #(
  parameter int MULDIV_EN = 1,
  parameter int ALU_OP_W  = 5
) (
  input  logic                cpu_clk,
  input  logic                cpu_rstn,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [31:0]         id_inst,
  input  logic [31:0]         id_pc,
  output logic                id_ready,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [31:0]         ex_pc,
  output logic [31:0]         ex_inst,
  output logic [4:0]          ex_rR1,
  output logic [4:0]          ex_rR2,
  output logic [4:0]          ex_wR,
  output logic [1:0]          ex_npc_op,
  output logic [2:0]          ex_ext_op,
  output logic [2:0]          ex_ram_ext_op,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_rf_we,
  output logic [3:0]          ex_ram_we,
  output logic [1:0]          ex_wd_sel,
  output logic [1:0]          ex_alua_sel,
  output logic                ex_alub_sel,
  output logic                ex_rR1_re,
  output logic                ex_rR2_re,
  output logic                ex_is_br_jump,
  output logic                ex_is_load,
  output logic                ex_is_md,
  output logic [2:0]          ex_md_op,
  output logic                ex_ill
);

  // Control-field encodings shared with EX/MEM/WB.
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JIRL = 2'd2, NPC_JMP = 2'd3;
  localparam logic [2:0] EXT_SI12 = 3'd1, EXT_UI12 = 3'd2, EXT_SI20 = 3'd3,
                         EXT_OFFS16 = 3'd4, EXT_OFFS26 = 3'd5, EXT_UI5 = 3'd6;
  localparam logic [2:0] REXT_B = 3'd1, REXT_BU = 3'd2, REXT_H = 3'd3, REXT_HU = 3'd4, REXT_W = 3'd5;
  localparam logic [1:0] WD_ALU = 2'd0, WD_RAM = 2'd1, WD_PC4 = 2'd2;
  localparam logic [1:0] A_R1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2;
  localparam logic       B_R2 = 1'b0, B_EXT = 1'b1;
  localparam logic [ALU_OP_W-1:0]
    ALU_ADD  = ALU_OP_W'(0),  ALU_SUB  = ALU_OP_W'(1),  ALU_SLT  = ALU_OP_W'(2),
    ALU_SLTU = ALU_OP_W'(3),  ALU_AND  = ALU_OP_W'(4),  ALU_OR   = ALU_OP_W'(5),
    ALU_XOR  = ALU_OP_W'(6),  ALU_NOR  = ALU_OP_W'(7),  ALU_SLL  = ALU_OP_W'(8),
    ALU_SRL  = ALU_OP_W'(9),  ALU_SRA  = ALU_OP_W'(10), ALU_BEQ  = ALU_OP_W'(11),
    ALU_BNE  = ALU_OP_W'(12), ALU_BLT  = ALU_OP_W'(13), ALU_BGE  = ALU_OP_W'(14),
    ALU_BLTU = ALU_OP_W'(15), ALU_BGEU = ALU_OP_W'(16);

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         inst;
    logic [4:0]          rr1;
    logic [4:0]          rr2;
    logic [4:0]          wr;
    logic [1:0]          npc_op;
    logic [2:0]          ext_op;
    logic [2:0]          ram_ext_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic                rf_we;
    logic [3:0]          ram_we;
    logic [1:0]          wd_sel;
    logic [1:0]          alua_sel;
    logic                alub_sel;
    logic                rr1_re;
    logic                rr2_re;
    logic                is_br_jump;
    logic                is_load;
    logic                is_md;
    logic [2:0]          md_op;
    logic                ill;
  } ctl_t;

  ctl_t d, ex_q;

  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;
  assign op17 = id_inst[31:15];
  assign op10 = id_inst[31:22];
  assign op7  = id_inst[31:25];
  assign op6  = id_inst[31:26];

  logic                r3, sh, i12, ld, st, md, brc, jirl, bl, legal;
  logic [ALU_OP_W-1:0] aop;
  logic [2:0]          eop, rext, mdop;
  logic [3:0]          wmask;

  // Combinational decode of the ID instruction; unmatched opcodes keep defaults and flag ill.
  always_comb begin
    d          = '0;
    d.pc       = id_pc;
    d.inst     = id_inst;
    d.rr1      = id_inst[9:5];
    d.npc_op   = NPC_PC4;
    d.wd_sel   = WD_ALU;
    d.alua_sel = A_R1;
    d.alub_sel = B_R2;
    d.alu_op   = ALU_ADD;
    r3 = 1'b0; sh = 1'b0; i12 = 1'b0; ld = 1'b0; st = 1'b0; md = 1'b0;
    brc = 1'b0; jirl = 1'b0; bl = 1'b0; legal = 1'b0;
    aop = ALU_ADD; eop = EXT_SI12; rext = '0; wmask = '0; mdop = '0;

    case (op17)
      17'h020: begin r3 = 1'b1; aop = ALU_ADD;  end
      17'h022: begin r3 = 1'b1; aop = ALU_SUB;  end
      17'h024: begin r3 = 1'b1; aop = ALU_SLT;  end
      17'h025: begin r3 = 1'b1; aop = ALU_SLTU; end
      17'h028: begin r3 = 1'b1; aop = ALU_NOR;  end
      17'h029: begin r3 = 1'b1; aop = ALU_AND;  end
      17'h02A: begin r3 = 1'b1; aop = ALU_OR;   end
      17'h02B: begin r3 = 1'b1; aop = ALU_XOR;  end
      17'h02E: begin r3 = 1'b1; aop = ALU_SLL;  end
      17'h02F: begin r3 = 1'b1; aop = ALU_SRL;  end
      17'h030: begin r3 = 1'b1; aop = ALU_SRA;  end
      17'h081: begin sh = 1'b1; aop = ALU_SLL;  end
      17'h089: begin sh = 1'b1; aop = ALU_SRL;  end
      17'h091: begin sh = 1'b1; aop = ALU_SRA;  end
      default: ;
    endcase

    // Mul/div opcodes only exist when the unit is built in.
    if (MULDIV_EN != 0) begin
      case (op17)
        17'h038: begin md = 1'b1; mdop = 3'd0; end
        17'h039: begin md = 1'b1; mdop = 3'd1; end
        17'h03A: begin md = 1'b1; mdop = 3'd2; end
        17'h040: begin md = 1'b1; mdop = 3'd4; end
        17'h041: begin md = 1'b1; mdop = 3'd5; end
        17'h042: begin md = 1'b1; mdop = 3'd6; end
        17'h043: begin md = 1'b1; mdop = 3'd7; end
        default: ;
      endcase
    end

    case (op10)
      10'h008: begin i12 = 1'b1; aop = ALU_SLT;  eop = EXT_SI12; end
      10'h009: begin i12 = 1'b1; aop = ALU_SLTU; eop = EXT_SI12; end
      10'h00A: begin i12 = 1'b1; aop = ALU_ADD;  eop = EXT_SI12; end
      10'h00D: begin i12 = 1'b1; aop = ALU_AND;  eop = EXT_UI12; end
      10'h00E: begin i12 = 1'b1; aop = ALU_OR;   eop = EXT_UI12; end
      10'h00F: begin i12 = 1'b1; aop = ALU_XOR;  eop = EXT_UI12; end
      10'h0A0: begin ld = 1'b1; rext = REXT_B;  end
      10'h0A1: begin ld = 1'b1; rext = REXT_H;  end
      10'h0A2: begin ld = 1'b1; rext = REXT_W;  end
      10'h0A8: begin ld = 1'b1; rext = REXT_BU; end
      10'h0A9: begin ld = 1'b1; rext = REXT_HU; end
      10'h0A4: begin st = 1'b1; wmask = 4'b0001; end
      10'h0A5: begin st = 1'b1; wmask = 4'b0011; end
      10'h0A6: begin st = 1'b1; wmask = 4'b1111; end
      default: ;
    endcase

    // Register-register ALU ops and mul/div share the R1/R2 datapath shape.
    if (r3 || md) begin
      legal = 1'b1; d.alu_op = aop; d.rf_we = 1'b1; d.rr1_re = 1'b1; d.rr2_re = 1'b1;
      d.alub_sel = B_R2; d.wd_sel = WD_ALU; d.is_md = md; d.md_op = mdop;
    end
    if (sh) begin
      legal = 1'b1; d.alu_op = aop; d.ext_op = EXT_UI5; d.alub_sel = B_EXT;
      d.rf_we = 1'b1; d.rr1_re = 1'b1;
    end
    if (i12) begin
      legal = 1'b1; d.alu_op = aop; d.ext_op = eop; d.alub_sel = B_EXT;
      d.rf_we = 1'b1; d.rr1_re = 1'b1;
    end
    if (ld) begin
      legal = 1'b1; d.ext_op = EXT_SI12; d.alub_sel = B_EXT; d.rf_we = 1'b1;
      d.rr1_re = 1'b1; d.wd_sel = WD_RAM; d.ram_ext_op = rext; d.is_load = 1'b1;
    end
    if (st) begin
      legal = 1'b1; d.ext_op = EXT_SI12; d.alub_sel = B_EXT;
      d.rr1_re = 1'b1; d.rr2_re = 1'b1; d.ram_we = wmask;
    end

    case (op7)
      7'h0A: begin legal = 1'b1; d.ext_op = EXT_SI20; d.alua_sel = A_ZERO; d.alub_sel = B_EXT; d.rf_we = 1'b1; end
      7'h0E: begin legal = 1'b1; d.ext_op = EXT_SI20; d.alua_sel = A_PC;   d.alub_sel = B_EXT; d.rf_we = 1'b1; end
      default: ;
    endcase

    case (op6)
      6'h13: begin jirl = 1'b1; d.npc_op = NPC_JIRL; d.ext_op = EXT_OFFS16; d.rr1_re = 1'b1;
                   d.rf_we = 1'b1; d.wd_sel = WD_PC4; end
      6'h14: begin legal = 1'b1; d.npc_op = NPC_JMP; d.ext_op = EXT_OFFS26; d.is_br_jump = 1'b1; end
      6'h15: begin bl = 1'b1; d.npc_op = NPC_JMP; d.ext_op = EXT_OFFS26; d.rf_we = 1'b1;
                   d.wd_sel = WD_PC4; end
      6'h16: begin brc = 1'b1; d.alu_op = ALU_BEQ;  end
      6'h17: begin brc = 1'b1; d.alu_op = ALU_BNE;  end
      6'h18: begin brc = 1'b1; d.alu_op = ALU_BLT;  end
      6'h19: begin brc = 1'b1; d.alu_op = ALU_BGE;  end
      6'h1A: begin brc = 1'b1; d.alu_op = ALU_BLTU; end
      6'h1B: begin brc = 1'b1; d.alu_op = ALU_BGEU; end
      default: ;
    endcase
    if (brc) begin
      d.npc_op = NPC_BR; d.ext_op = EXT_OFFS16; d.rr1_re = 1'b1; d.rr2_re = 1'b1; d.alub_sel = B_R2;
    end
    if (brc || jirl || bl) begin
      legal = 1'b1; d.is_br_jump = 1'b1;
    end

    // Stores and compare-branches read rd as their second operand; bl links into r1.
    d.rr2 = (st || brc || jirl) ? id_inst[4:0] : id_inst[14:10];
    d.wr  = bl ? 5'd1 : id_inst[4:0];
    d.ill = ~legal;
  end

  logic adv, lu;
  assign adv = !ex_valid || ex_ready;
  // A load in EX whose (nonzero) destination feeds an operand the ID instruction reads.
  assign lu  = ex_valid && ex_q.is_load && (ex_q.wr != 5'd0) &&
               ((d.rr1_re && (d.rr1 == ex_q.wr)) || (d.rr2_re && (d.rr2 == ex_q.wr)));
  assign id_ready = adv && !lu && !flush;

  // EX output register: flush beats interlock bubble beats normal advance; otherwise hold.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush || (adv && lu)) begin
      ex_valid     <= 1'b0;
      ex_q.rf_we   <= 1'b0;
      ex_q.ram_we  <= '0;
    end else if (adv) begin
      ex_valid    <= id_valid;
      ex_q        <= d;
      ex_q.rf_we  <= id_valid & d.rf_we;
      ex_q.ram_we <= id_valid ? d.ram_we : 4'b0000;
    end
  end

  assign ex_pc         = ex_q.pc;
  assign ex_inst       = ex_q.inst;
  assign ex_rR1        = ex_q.rr1;
  assign ex_rR2        = ex_q.rr2;
  assign ex_wR         = ex_q.wr;
  assign ex_npc_op     = ex_q.npc_op;
  assign ex_ext_op     = ex_q.ext_op;
  assign ex_ram_ext_op = ex_q.ram_ext_op;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_rf_we      = ex_q.rf_we;
  assign ex_ram_we     = ex_q.ram_we;
  assign ex_wd_sel     = ex_q.wd_sel;
  assign ex_alua_sel   = ex_q.alua_sel;
  assign ex_alub_sel   = ex_q.alub_sel;
  assign ex_rR1_re     = ex_q.rr1_re;
  assign ex_rR2_re     = ex_q.rr2_re;
  assign ex_is_br_jump = ex_q.is_br_jump;
  assign ex_is_load    = ex_q.is_load;
  assign ex_is_md      = ex_q.is_md;
  assign ex_md_op      = ex_q.md_op;
  assign ex_ill        = ex_q.ill;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed instructions with hand-computed
// decode results; a monitor compares every live EX output against the queue head.
module tb_id_decode_stage;

  logic        cpu_clk = 1'b0, cpu_rstn = 1'b0, flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b1;
  logic [31:0] id_inst = '0, id_pc = '0;
  logic        id_ready, ex_valid, ex_rf_we, ex_alub_sel, ex_rR1_re, ex_rR2_re;
  logic        ex_is_br_jump, ex_is_load, ex_is_md, ex_ill;
  logic [31:0] ex_pc, ex_inst;
  logic [4:0]  ex_rR1, ex_rR2, ex_wR, ex_alu_op;
  logic [1:0]  ex_npc_op, ex_wd_sel, ex_alua_sel;
  logic [2:0]  ex_ext_op, ex_ram_ext_op, ex_md_op;
  logic [3:0]  ex_ram_we;
  // second instance built without mul/div
  logic        m0_id_ready, m0_ex_valid, m0_ex_rf_we, m0_ex_alub_sel, m0_ex_rR1_re, m0_ex_rR2_re;
  logic        m0_ex_is_br_jump, m0_ex_is_load, m0_ex_is_md, m0_ex_ill;
  logic [31:0] m0_ex_pc, m0_ex_inst;
  logic [4:0]  m0_ex_rR1, m0_ex_rR2, m0_ex_wR, m0_ex_alu_op;
  logic [1:0]  m0_ex_npc_op, m0_ex_wd_sel, m0_ex_alua_sel;
  logic [2:0]  m0_ex_ext_op, m0_ex_ram_ext_op, m0_ex_md_op;
  logic [3:0]  m0_ex_ram_we;

  always #5 cpu_clk = ~cpu_clk;

  id_decode_stage #(.MULDIV_EN(1), .ALU_OP_W(5)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .flush(flush), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rR1(ex_rR1),
    .ex_rR2(ex_rR2), .ex_wR(ex_wR), .ex_npc_op(ex_npc_op), .ex_ext_op(ex_ext_op),
    .ex_ram_ext_op(ex_ram_ext_op), .ex_alu_op(ex_alu_op), .ex_rf_we(ex_rf_we),
    .ex_ram_we(ex_ram_we), .ex_wd_sel(ex_wd_sel), .ex_alua_sel(ex_alua_sel),
    .ex_alub_sel(ex_alub_sel), .ex_rR1_re(ex_rR1_re), .ex_rR2_re(ex_rR2_re),
    .ex_is_br_jump(ex_is_br_jump), .ex_is_load(ex_is_load), .ex_is_md(ex_is_md),
    .ex_md_op(ex_md_op), .ex_ill(ex_ill));

  id_decode_stage #(.MULDIV_EN(0), .ALU_OP_W(5)) u0 (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .flush(flush), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .id_ready(m0_id_ready), .ex_valid(m0_ex_valid),
    .ex_ready(ex_ready), .ex_pc(m0_ex_pc), .ex_inst(m0_ex_inst), .ex_rR1(m0_ex_rR1),
    .ex_rR2(m0_ex_rR2), .ex_wR(m0_ex_wR), .ex_npc_op(m0_ex_npc_op), .ex_ext_op(m0_ex_ext_op),
    .ex_ram_ext_op(m0_ex_ram_ext_op), .ex_alu_op(m0_ex_alu_op), .ex_rf_we(m0_ex_rf_we),
    .ex_ram_we(m0_ex_ram_we), .ex_wd_sel(m0_ex_wd_sel), .ex_alua_sel(m0_ex_alua_sel),
    .ex_alub_sel(m0_ex_alub_sel), .ex_rR1_re(m0_ex_rR1_re), .ex_rR2_re(m0_ex_rR2_re),
    .ex_is_br_jump(m0_ex_is_br_jump), .ex_is_load(m0_ex_is_load), .ex_is_md(m0_ex_is_md),
    .ex_md_op(m0_ex_md_op), .ex_ill(m0_ex_ill));

  typedef struct packed {
    logic [31:0] inst, pc;
    logic [4:0]  rr1, rr2, wr;
    logic [1:0]  npc;
    logic [2:0]  ext, rext;
    logic [4:0]  alu;
    logic        rf_we;
    logic [3:0]  ram_we;
    logic [1:0]  wd, alua;
    logic        alub, r1re, r2re, br, ld, md;
    logic [2:0]  mdop;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t blank(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e = '0; e.inst = inst; e.pc = pc;
    return e;
  endfunction

  // Monitor: compare live EX outputs with the queue head; pop when EX consumes or flush kills it.
  initial forever begin
    @(negedge cpu_clk); #2;
    if (cpu_rstn) begin
      if (ex_valid) begin
        if (q.size() == 0) check("unexpected_output", 32'(ex_valid), 32'd0);
        else begin
          check("inst",     ex_inst,                 q[0].inst);
          check("pc",       ex_pc,                   q[0].pc);
          check("rR1",      32'(ex_rR1),             32'(q[0].rr1));
          check("rR2",      32'(ex_rR2),             32'(q[0].rr2));
          check("wR",       32'(ex_wR),              32'(q[0].wr));
          check("npc_op",   32'(ex_npc_op),          32'(q[0].npc));
          check("ext_op",   32'(ex_ext_op),          32'(q[0].ext));
          check("ram_ext",  32'(ex_ram_ext_op),      32'(q[0].rext));
          check("alu_op",   32'(ex_alu_op),          32'(q[0].alu));
          check("rf_we",    32'(ex_rf_we),           32'(q[0].rf_we));
          check("ram_we",   32'(ex_ram_we),          32'(q[0].ram_we));
          check("wd_sel",   32'(ex_wd_sel),          32'(q[0].wd));
          check("alua_sel", 32'(ex_alua_sel),        32'(q[0].alua));
          check("alub_sel", 32'(ex_alub_sel),        32'(q[0].alub));
          check("rR1_re",   32'(ex_rR1_re),          32'(q[0].r1re));
          check("rR2_re",   32'(ex_rR2_re),          32'(q[0].r2re));
          check("br_jump",  32'(ex_is_br_jump),      32'(q[0].br));
          check("is_load",  32'(ex_is_load),         32'(q[0].ld));
          check("is_md",    32'(ex_is_md),           32'(q[0].md));
          check("md_op",    32'(ex_md_op),           32'(q[0].mdop));
          check("ill",      32'(ex_ill),             32'(q[0].ill));
          if (q[0].md) begin
            // without mul/div the same word is illegal and must not write
            check("nomd_valid", 32'(m0_ex_valid), 32'd1);
            check("nomd_ill",   32'(m0_ex_ill),   32'd1);
            check("nomd_rf_we", 32'(m0_ex_rf_we), 32'd0);
            check("nomd_is_md", 32'(m0_ex_is_md), 32'd0);
          end
          if (ex_ready || flush) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        check("latency_valid", 32'(ex_valid), 32'd1);
      end
    end
  end

  // Offer one instruction until accepted; reports stall cycles and ex_valid in the accepting cycle.
  task automatic issue(input exp_t e, output int stalls, output logic v_acc);
    logic acc;
    int   n;
    acc = 1'b0; n = 0; stalls = 0; v_acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge cpu_clk);
      id_valid = 1'b1; id_inst = e.inst; id_pc = e.pc;
      #1;
      acc = id_ready; v_acc = ex_valid;
      @(posedge cpu_clk);
      if (acc) q.push_back(e);
      else stalls++;
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  exp_t V_ADD, V_ADDI, V_LU12I, V_BEQ, V_ILL, V_MUL, V_MODWU, V_LD4, V_ADDDEP, V_ADDR0, V_LDR0, V_STW, V_BL;
  int   st;
  logic va;

  initial begin
    // add.w r3,r1,r2
    V_ADD = blank(32'h00100823, 32'h1c000000);
    V_ADD.rr1 = 1; V_ADD.rr2 = 2; V_ADD.wr = 3; V_ADD.rf_we = 1; V_ADD.r1re = 1; V_ADD.r2re = 1;
    // addi.w r8,r1,-1 : SI12 ext, operand B from ext
    V_ADDI = blank(32'h02BFFC28, 32'h1c000004);
    V_ADDI.rr1 = 1; V_ADDI.rr2 = 31; V_ADDI.wr = 8; V_ADDI.ext = 1; V_ADDI.alub = 1;
    V_ADDI.rf_we = 1; V_ADDI.r1re = 1;
    // lu12i.w r9,0x12345 : SI20, operand A zero
    V_LU12I = blank(32'h142468A9, 32'h1c000008);
    V_LU12I.rr1 = 5; V_LU12I.rr2 = 26; V_LU12I.wr = 9; V_LU12I.ext = 3; V_LU12I.alua = 2;
    V_LU12I.alub = 1; V_LU12I.rf_we = 1;
    // beq r1,r2 : rR2 comes from rd
    V_BEQ = blank(32'h58000022, 32'h1c00000c);
    V_BEQ.rr1 = 1; V_BEQ.rr2 = 2; V_BEQ.wr = 2; V_BEQ.npc = 1; V_BEQ.ext = 4; V_BEQ.alu = 11;
    V_BEQ.r1re = 1; V_BEQ.r2re = 1; V_BEQ.br = 1;
    // all-ones word is not an instruction
    V_ILL = blank(32'hFFFFFFFF, 32'h1c000010);
    V_ILL.rr1 = 31; V_ILL.rr2 = 31; V_ILL.wr = 31; V_ILL.ill = 1;
    // mul.w r6,r1,r2
    V_MUL = blank(32'h001C0826, 32'h1c000014);
    V_MUL.rr1 = 1; V_MUL.rr2 = 2; V_MUL.wr = 6; V_MUL.rf_we = 1; V_MUL.r1re = 1; V_MUL.r2re = 1;
    V_MUL.md = 1; V_MUL.mdop = 0;
    // mod.wu r7,r1,r2
    V_MODWU = blank(32'h00218827, 32'h1c000018);
    V_MODWU.rr1 = 1; V_MODWU.rr2 = 2; V_MODWU.wr = 7; V_MODWU.rf_we = 1; V_MODWU.r1re = 1;
    V_MODWU.r2re = 1; V_MODWU.md = 1; V_MODWU.mdop = 7;
    // ld.w r4,r1,0
    V_LD4 = blank(32'h28800024, 32'h1c000020);
    V_LD4.rr1 = 1; V_LD4.rr2 = 0; V_LD4.wr = 4; V_LD4.ext = 1; V_LD4.rext = 5; V_LD4.rf_we = 1;
    V_LD4.wd = 1; V_LD4.alub = 1; V_LD4.r1re = 1; V_LD4.ld = 1;
    // add.w r5,r4,r2 (depends on r4)
    V_ADDDEP = blank(32'h00100885, 32'h1c000024);
    V_ADDDEP.rr1 = 4; V_ADDDEP.rr2 = 2; V_ADDDEP.wr = 5; V_ADDDEP.rf_we = 1; V_ADDDEP.r1re = 1; V_ADDDEP.r2re = 1;
    // add.w r5,r0,r2
    V_ADDR0 = blank(32'h00100805, 32'h1c000028);
    V_ADDR0.rr1 = 0; V_ADDR0.rr2 = 2; V_ADDR0.wr = 5; V_ADDR0.rf_we = 1; V_ADDR0.r1re = 1; V_ADDR0.r2re = 1;
    // ld.w r0,r1,0
    V_LDR0 = V_LD4; V_LDR0.inst = 32'h28800020; V_LDR0.pc = 32'h1c00002c; V_LDR0.wr = 0;
    // st.w r4,r1,0 : stored data register is rd
    V_STW = blank(32'h29800024, 32'h1c000030);
    V_STW.rr1 = 1; V_STW.rr2 = 4; V_STW.wr = 4; V_STW.ext = 1; V_STW.alub = 1; V_STW.ram_we = 4'hF;
    V_STW.r1re = 1; V_STW.r2re = 1;
    // bl : links into r1
    V_BL = blank(32'h54000000, 32'h1c000040);
    V_BL.wr = 1; V_BL.npc = 3; V_BL.ext = 5; V_BL.rf_we = 1; V_BL.wd = 2; V_BL.br = 1;

    // reset state
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_inst",  ex_inst,       32'd0);
    check("rst_ex_wR",    32'(ex_wR),    32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    @(negedge cpu_clk); cpu_rstn = 1'b1;

    // back-to-back decode of assorted classes
    issue(V_ADD, st, va);   check("add_stalls", 32'(st), 32'd0);
    issue(V_ADDI, st, va);  issue(V_LU12I, st, va); issue(V_BEQ, st, va);
    issue(V_ILL, st, va);   issue(V_MUL, st, va);   issue(V_MODWU, st, va);
    check("b2b_stalls", 32'(st), 32'd0);

    // load-use on rR1: one bubble
    issue(V_LD4, st, va);
    issue(V_ADDDEP, st, va);
    check("lu_stalls", 32'(st), 32'd1);
    check("lu_bubble", 32'(va), 32'd0);
    // source r0 / other reg: no stall
    issue(V_LD4, st, va);
    issue(V_ADDR0, st, va);
    check("nolu_stalls", 32'(st), 32'd0);
    // load into r0 never interlocks
    issue(V_LDR0, st, va);
    issue(V_ADDR0, st, va);
    check("ldr0_stalls", 32'(st), 32'd0);
    // load-use through the store data operand
    issue(V_LD4, st, va);
    issue(V_STW, st, va);
    check("lu_st_stalls", 32'(st), 32'd1);

    // EX backpressure for 3 cycles; next instruction loads on release edge
    issue(V_ADD, st, va);
    fork
      begin @(negedge cpu_clk); ex_ready = 1'b0; repeat (3) @(negedge cpu_clk); ex_ready = 1'b1; end
      begin issue(V_LU12I, st, va); end
    join
    check("hold_stalls", 32'(st), 32'd3);

    // flush with ex_ready=0 kills EX and the offered instruction
    issue(V_BEQ, st, va);
    @(negedge cpu_clk);
    ex_ready = 1'b0; flush = 1'b1; id_valid = 1'b1; id_inst = V_ILL.inst; id_pc = V_ILL.pc;
    #1 check("flush_id_ready", 32'(id_ready), 32'd0);
    @(negedge cpu_clk);
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    #1 check("flush_ex_valid", 32'(ex_valid), 32'd0);

    // asynchronous reset between edges
    issue(V_ADD, st, va);
    @(negedge cpu_clk); id_valid = 1'b0;
    #3 cpu_rstn = 1'b0;
    #1;
    check("arst_ex_valid", 32'(ex_valid),  32'd0);
    check("arst_ex_inst",  ex_inst,        32'd0);
    check("arst_ex_pc",    ex_pc,          32'd0);
    check("arst_ex_rR1",   32'(ex_rR1),    32'd0);
    check("arst_ex_wR",    32'(ex_wR),     32'd0);
    check("arst_rf_we",    32'(ex_rf_we),  32'd0);
    check("arst_id_ready", 32'(id_ready),  32'd1);
    q.delete();
    @(negedge cpu_clk); cpu_rstn = 1'b1;
    issue(V_BL, st, va);
    check("bl_stalls", 32'(st), 32'd0);

    @(negedge cpu_clk); id_valid = 1'b0;
    repeat (4) @(negedge cpu_clk);
    #3 check("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
